// File: rtl/fft_pkg.sv
// Shared definitions for the FFT output reorder buffer: size select encoding,
// read-FSM state type and index helpers.
package fft_pkg;

  localparam logic [1:0] SEL_16  = 2'b00;
  localparam logic [1:0] SEL_32  = 2'b11;
  localparam logic [1:0] SEL_64  = 2'b01;
  localparam logic [1:0] SEL_128 = 2'b10;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_READ = 1'b1
  } rd_state_t;

  function automatic int unsigned size_from_sel(input logic [1:0] sel_in);
    case (sel_in)
      SEL_16:  return 16;
      SEL_32:  return 32;
      SEL_64:  return 64;
      default: return 128;
    endcase
  endfunction

  function automatic int unsigned log2(input int unsigned value);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if (value > (32'd1 << i)) r = i + 1;
    end
    return r;
  endfunction

  // Reverses the low k bits of value.
  function automatic int unsigned bitrev(input int unsigned value, input int unsigned k);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if (i < k) r = {r[30:0], value[i]};
    end
    return r;
  endfunction

endpackage

// File: rtl/fft_reorder_ram.sv
// Simple dual-port sample store: one write port, one read port with a
// registered read. Both ping-pong banks live in one array.
module reorder_ram #(
  parameter int DW = 32,
  parameter int AW = 8
) (
  input  logic          i_clock,
  input  logic          i_wr_en,
  input  logic [AW-1:0] i_wr_addr,
  input  logic [DW-1:0] i_wr_data,
  input  logic          i_rd_en,
  input  logic [AW-1:0] i_rd_addr,
  output logic [DW-1:0] o_rd_data
);

  logic [DW-1:0] r_mem [2**AW];

  always_ff @(posedge i_clock) begin
    if (i_wr_en) r_mem[i_wr_addr] <= i_wr_data;
    if (i_rd_en) o_rd_data <= r_mem[i_rd_addr];
  end

endmodule

// File: rtl/fft_reorder.sv
// Bit-reversed to natural order reorder buffer with ping-pong banks.
// Define FFT_REORDER_FFTSHIFT_EN to output DC-centred (bins N/2..N-1, 0..N/2-1).
//   state   | meaning
//   ST_IDLE | no bank being read; issues address 0 as soon as a bank is full
//   ST_READ | streaming the remaining addresses of the current read bank
module fft_reorder
  import fft_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int MAX_N = 128
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [1:0]       sel,
  input  logic             di_en,
  input  logic [WIDTH-1:0] di_re,
  input  logic [WIDTH-1:0] di_im,
  output logic             do_en,
  output logic [WIDTH-1:0] do_re,
  output logic [WIDTH-1:0] do_im,
  output logic             ovf
);

  localparam int CW = $clog2(MAX_N);
  localparam int NW = CW + 1;

  rd_state_t        r_state, w_state_nxt;
  logic             r_wr_bank, r_rd_bank;
  logic [CW-1:0]    r_wr_cnt, r_rd_cnt;
  logic [NW-1:0]    r_wr_n;
  logic [NW-1:0]    r_bank_n [2];
  logic [1:0]       r_full;
  logic             r_do_en, r_ovf;

  logic [NW-1:0]    w_sel_n, w_wr_n, w_rd_n;
  logic             w_wr_first, w_wr_blocked, w_wr_acc, w_wr_last;
  logic             w_rel, w_other_full, w_rd_act;
  logic [CW-1:0]    w_wr_idx, w_rd_idx, w_rd_cnt_nxt, w_rd_ofs;
  logic [2*WIDTH-1:0] w_rd_data;

  assign w_sel_n    = (size_from_sel(sel) > MAX_N) ? NW'(MAX_N) : NW'(size_from_sel(sel));
  assign w_wr_first = (r_wr_cnt == '0);
  assign w_wr_n     = w_wr_first ? w_sel_n : r_wr_n;
  assign w_wr_idx   = CW'(bitrev(32'(r_wr_cnt), log2(32'(w_wr_n))));

  // A bank being released this cycle may already take the next frame's first sample.
  assign w_wr_blocked = r_full[r_wr_bank] && !(w_rel && (r_rd_bank == r_wr_bank));
  assign w_wr_acc     = reset && di_en && !w_wr_blocked;
  assign w_wr_last    = w_wr_acc && ({1'b0, r_wr_cnt} == w_wr_n - NW'(1));

  assign w_rd_n       = r_bank_n[r_rd_bank];
  assign w_rel        = (r_state == ST_READ) && ({1'b0, r_rd_cnt} == w_rd_n - NW'(1));
  assign w_other_full = r_full[~r_rd_bank] || (w_wr_last && (r_wr_bank != r_rd_bank));

`ifdef FFT_REORDER_FFTSHIFT_EN
  assign w_rd_ofs = CW'(w_rd_n >> 1);
`else
  assign w_rd_ofs = '0;
`endif

  always_comb begin
    w_state_nxt  = r_state;
    w_rd_act     = 1'b0;
    w_rd_idx     = r_rd_cnt;
    w_rd_cnt_nxt = r_rd_cnt;
    case (r_state)
      ST_IDLE: begin
        if (r_full[r_rd_bank]) begin
          w_rd_act     = 1'b1;
          w_rd_idx     = '0;
          w_rd_cnt_nxt = CW'(1);
          w_state_nxt  = ST_READ;
        end
      end
      ST_READ: begin
        w_rd_act = 1'b1;
        if (w_rel) begin
          w_rd_cnt_nxt = '0;
          w_state_nxt  = w_other_full ? ST_READ : ST_IDLE;
        end else begin
          w_rd_cnt_nxt = r_rd_cnt + CW'(1);
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state     <= ST_IDLE;
      r_wr_bank   <= 1'b0;
      r_rd_bank   <= 1'b0;
      r_wr_cnt    <= '0;
      r_rd_cnt    <= '0;
      r_wr_n      <= NW'(MAX_N);
      r_bank_n[0] <= NW'(MAX_N);
      r_bank_n[1] <= NW'(MAX_N);
      r_full      <= '0;
      r_do_en     <= 1'b0;
      r_ovf       <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_rd_cnt <= w_rd_cnt_nxt;
      r_do_en  <= w_rd_act;
      if (di_en && w_wr_blocked) r_ovf <= 1'b1;
      if (w_wr_acc && w_wr_first) r_wr_n <= w_sel_n;
      if (w_wr_acc) r_wr_cnt <= w_wr_last ? '0 : r_wr_cnt + CW'(1);
      if (w_rel) begin
        r_full[r_rd_bank] <= 1'b0;
        r_rd_bank         <= ~r_rd_bank;
      end
      if (w_wr_last) begin
        r_full[r_wr_bank]   <= 1'b1;
        r_bank_n[r_wr_bank] <= w_wr_n;
        r_wr_bank           <= ~r_wr_bank;
      end
    end
  end

  reorder_ram #(
    .DW(2*WIDTH),
    .AW(CW+1)
  ) u_ram (
    .i_clock   (clock),
    .i_wr_en   (w_wr_acc),
    .i_wr_addr ({r_wr_bank, w_wr_idx}),
    .i_wr_data ({di_re, di_im}),
    .i_rd_en   (w_rd_act),
    .i_rd_addr ({r_rd_bank, w_rd_idx ^ w_rd_ofs}),
    .o_rd_data (w_rd_data)
  );

  assign do_en = r_do_en;
  assign do_re = r_do_en ? w_rd_data[2*WIDTH-1:WIDTH] : '0;
  assign do_im = r_do_en ? w_rd_data[WIDTH-1:0]       : '0;
  assign ovf   = r_ovf;

endmodule

// File: tb/tb_fft_reorder.sv
// Self-checking bench for fft_reorder: directed frame table, multi-frame and
// reset/overflow sequences, and randomized frames against a queue model.
module tb_fft_reorder;

  localparam int WIDTH = 16;
  localparam int MAX_N = 128;
`ifdef FFT_REORDER_FFTSHIFT_EN
  localparam bit SHIFT = 1'b1;
`else
  localparam bit SHIFT = 1'b0;
`endif

  logic             clock = 1'b0;
  logic             reset = 1'b0;
  logic [1:0]       sel   = 2'b00;
  logic             di_en = 1'b0;
  logic [WIDTH-1:0] di_re = '0;
  logic [WIDTH-1:0] di_im = '0;
  logic             do_en;
  logic [WIDTH-1:0] do_re, do_im;
  logic             ovf;

  fft_reorder #(.WIDTH(WIDTH), .MAX_N(MAX_N)) dut (
    .clock(clock), .reset(reset), .sel(sel), .di_en(di_en), .di_re(di_re), .di_im(di_im),
    .do_en(do_en), .do_re(do_re), .do_im(do_im), .ovf(ovf)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_in = 0;
  int run_len = 0;
  logic prev_en = 1'b0;
  logic [2*WIDTH-1:0] exp_q[$];
  logic [2*WIDTH-1:0] mon_e;
  int run_start_q[$];
  int run_len_q[$];
  int run_v0_q[$];
  int run_v1_q[$];
  logic [WIDTH-1:0] fr_re [MAX_N];
  logic [WIDTH-1:0] fr_im [MAX_N];

  typedef struct {
    logic [1:0] sel;
    int gap_at;
    int exp_n;
    int exp_first;
    int exp_second;
  } vec_t;
  vec_t vecs[4];

  function automatic int sel_to_n(input logic [1:0] s);
    case (s)
      2'b00:   return 16;
      2'b11:   return 32;
      2'b01:   return 64;
      default: return 128;
    endcase
  endfunction

  function automatic int ref_bitrev(input int v, input int k);
    int r = 0;
    for (int j = 0; j < k; j++) begin
      r = r * 2 + (v % 2);
      v = v / 2;
    end
    return r;
  endfunction

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Natural-order bin i holds the sample that arrived at position bitrev(i).
  task automatic push_expected(input int n);
    int k, idx, p;
    k = $clog2(n);
    for (int i = 0; i < n; i++) begin
      idx = SHIFT ? (i ^ (n / 2)) : i;
      p = ref_bitrev(idx, k);
      exp_q.push_back({fr_re[p], fr_im[p]});
    end
  endtask

  always @(posedge clock) cyc++;

  always @(negedge clock) begin
    if (do_en === 1'b1) begin
      if (!prev_en) begin
        run_start_q.push_back(cyc);
        run_v0_q.push_back(int'(do_re));
      end
      if (run_len == 1) run_v1_q.push_back(int'(do_re));
      run_len++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output: got re=%0d im=%0d, expected no output", do_re, do_im);
      end else begin
        mon_e = exp_q.pop_front();
        check("out_re", do_re, mon_e[2*WIDTH-1:WIDTH]);
        check("out_im", do_im, mon_e[WIDTH-1:0]);
      end
    end else begin
      if (prev_en) run_len_q.push_back(run_len);
      run_len = 0;
      check("idle_zero", {do_re, do_im}, 0);
    end
    prev_en = (do_en === 1'b1);
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clock); #1;
      di_en = 1'b0;
    end
  endtask

  task automatic send_frame(input logic [1:0] s, input int gap_at, input bit rnd, input bit push);
    int n;
    n = sel_to_n(s);
    for (int p = 0; p < n; p++) begin
      if (rnd) begin
        while ($urandom_range(0, 3) == 0) begin
          @(posedge clock); #1;
          di_en = 1'b0;
          sel = 2'($urandom);
        end
      end
      @(posedge clock); #1;
      di_en = 1'b1;
      sel = (p == 0 || !rnd) ? s : 2'($urandom);
      fr_re[p] = rnd ? WIDTH'($urandom) : WIDTH'(p);
      fr_im[p] = rnd ? WIDTH'($urandom) : WIDTH'(-p);
      di_re = fr_re[p];
      di_im = fr_im[p];
      last_in = cyc;
      if (p == gap_at) begin
        @(posedge clock); #1;
        di_en = 1'b0;
      end
    end
    if (push) push_expected(n);
  endtask

  task automatic wait_drain(input string name);
    int t = 0;
    while ((exp_q.size() != 0 || do_en === 1'b1) && t < 3000) begin
      @(negedge clock);
      t++;
    end
    repeat (2) @(negedge clock);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_drain: %0d outputs missing after timeout, expected 0", name, exp_q.size());
      exp_q.delete();
    end
    @(posedge clock); #1;
  endtask

  task automatic clear_runs();
    run_start_q.delete();
    run_len_q.delete();
    run_v0_q.delete();
    run_v1_q.delete();
  endtask

  task automatic check_run(input string name, input int t_last, input int exp_len);
    check({name, "_nruns"}, run_len_q.size(), 1);
    if (run_len_q.size() >= 1 && run_start_q.size() >= 1) begin
      check({name, "_latency"}, run_start_q[0] - t_last, 2);
      check({name, "_len"}, run_len_q[0], exp_len);
    end
  endtask

  int t1, total;
  logic [1:0] rs;

  initial begin
    vecs[0] = '{2'b11, -1, 32,  SHIFT ? 1 : 0, SHIFT ? 17 : 16};
    vecs[1] = '{2'b00,  5, 16,  SHIFT ? 1 : 0, SHIFT ? 9  : 8};
    vecs[2] = '{2'b01, -1, 64,  SHIFT ? 1 : 0, SHIFT ? 33 : 32};
    vecs[3] = '{2'b10, 100, 128, SHIFT ? 1 : 0, SHIFT ? 65 : 64};

    reset = 1'b0;
    repeat (3) @(posedge clock);
    #1 reset = 1'b1;
    @(negedge clock);
    check("rst_do_en", do_en, 0);
    check("rst_do_re", do_re, 0);
    check("rst_do_im", do_im, 0);
    check("rst_ovf", ovf, 0);
    @(posedge clock); #1;

    foreach (vecs[v]) begin
      clear_runs();
      send_frame(vecs[v].sel, vecs[v].gap_at, 1'b0, 1'b1);
      idle(1);
      wait_drain($sformatf("vec%0d", v));
      check_run($sformatf("vec%0d", v), last_in, vecs[v].exp_n);
      if (run_v0_q.size() >= 1 && run_v1_q.size() >= 1) begin
        check($sformatf("vec%0d_first", v), run_v0_q[0], vecs[v].exp_first);
        check($sformatf("vec%0d_second", v), run_v1_q[0], vecs[v].exp_second);
      end
    end

    // Two back-to-back 128-point frames stream out without a gap.
    clear_runs();
    send_frame(2'b10, -1, 1'b0, 1'b1);
    t1 = last_in;
    send_frame(2'b10, -1, 1'b0, 1'b1);
    idle(1);
    wait_drain("b2b2");
    check_run("b2b2", t1, 256);
    check("b2b2_ovf", ovf, 0);

    clear_runs();
    send_frame(2'b10, -1, 1'b0, 1'b1);
    t1 = last_in;
    send_frame(2'b10, -1, 1'b0, 1'b1);
    send_frame(2'b10, -1, 1'b0, 1'b1);
    idle(1);
    wait_drain("b2b3");
    check_run("b2b3", t1, 384);
    check("b2b3_ovf", ovf, 0);

    // 128 then three 16s: the third and fourth frames hit a bank still being read.
    clear_runs();
    send_frame(2'b10, -1, 1'b0, 1'b1);
    t1 = last_in;
    send_frame(2'b00, -1, 1'b0, 1'b1);
    send_frame(2'b00, -1, 1'b0, 1'b0);
    send_frame(2'b00, -1, 1'b0, 1'b0);
    idle(1);
    wait_drain("ovfseq");
    check_run("ovfseq", t1, 144);
    check("ovfseq_ovf", ovf, 1);

    // Reset at sample 10 of a 64-point frame abandons it.
    clear_runs();
    for (int p = 0; p <= 10; p++) begin
      @(posedge clock); #1;
      di_en = 1'b1;
      sel = 2'b01;
      di_re = WIDTH'(p + 1000);
      di_im = WIDTH'(p);
      if (p == 10) reset = 1'b0;
    end
    @(posedge clock); #1;
    reset = 1'b1;
    di_en = 1'b0;
    @(negedge clock);
    check("rst_mid_ovf", ovf, 0);
    check("rst_mid_do_en", do_en, 0);
    @(posedge clock); #1;
    idle(40);
    check("rst_mid_no_out", run_start_q.size(), 0);
    send_frame(2'b01, -1, 1'b0, 1'b1);
    idle(1);
    wait_drain("after_rst");
    check_run("after_rst", last_in, 64);

    for (int b = 0; b < 3; b++) begin
      clear_runs();
      rs = 2'($urandom);
      for (int f = 0; f < 3; f++) begin
        send_frame(rs, -1, 1'b1, 1'b1);
        idle($urandom_range(0, 2));
      end
      idle(1);
      wait_drain($sformatf("rnd%0d", b));
      total = 0;
      foreach (run_len_q[i]) total += run_len_q[i];
      check($sformatf("rnd%0d_total", b), total, 3 * sel_to_n(rs));
      check($sformatf("rnd%0d_ovf", b), ovf, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation still running, expected finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/fft_reorder.md
FFT_REORDER -- requirements
Module: fft_reorder

Interface
REQ-001 SHALL have parameter WIDTH, default 16, bit width of each real/imag sample.
REQ-002 SHALL have parameter MAX_N, default 128, largest frame size; power of two.
REQ-003 SHALL have port clock  input  1  sole clock; all logic on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-low reset.
REQ-005 SHALL have port sel  input  2  frame size: 00=16, 11=32, 01=64, 10=128 points.
REQ-006 SHALL have port di_en  input  1  input sample valid, bit-reversed FFT order.
REQ-007 SHALL have ports di_re, di_im  input  WIDTH  input sample real/imag.
REQ-008 SHALL have port do_en  output  1  output sample valid, natural order.
REQ-009 SHALL have ports do_re, do_im  output  WIDTH  output sample real/imag.
REQ-010 SHALL have port ovf  output  1  sticky flag: an input sample was dropped.

Function
REQ-011 SHALL hold two MAX_N-entry banks (ping-pong); one bank is written while the other is read.
REQ-012 SHALL latch sel into the write bank's size N on the first di_en of each frame; sel changes mid-frame are ignored.
REQ-013 SHALL write the p-th accepted sample (p=0..N-1) at address bitrev_k(p), k=log2(N).
REQ-014 SHALL advance the write counter only on di_en=1; gaps within a frame are allowed.
REQ-015 SHALL mark the write bank full and swap write banks after sample N-1; the counter wraps to 0.
REQ-016 SHALL run the read FSM with states IDLE, READ: IDLE->READ when a bank is full; READ->IDLE after N reads; READ->READ (next bank) if the other bank is full at that point.
REQ-017 SHALL read addresses 0..N-1 with that bank's latched N, one per cycle.
REQ-018 SHALL assert do_en for exactly N consecutive cycles per frame; do_re/do_im are registered.
REQ-019 SHALL assert the first do_en 2 cycles after the cycle of the last input sample when the reader is idle.
REQ-020 SHALL release a bank (clear full) in the cycle of its last read, so a write to it in the same cycle is accepted.
REQ-021 SHALL drop a sample arriving while the write bank is still full, and set ovf; the write counter does not advance.
REQ-022 SHALL drive do_re/do_im to 0 whenever do_en=0.

Reset
REQ-023 SHALL, on reset=0 at a clock edge, set do_en=0, do_re=do_im=0, ovf=0, both banks empty, both counters 0 and FSM=IDLE, effective the next cycle.
REQ-024 SHALL abandon any partial input frame and any in-progress output frame on reset; memory contents are not cleared.

Configuration
REQ-025 SHALL honour macro FFT_REORDER_FFTSHIFT_EN: when defined, the read address is i XOR N/2, so the output runs bins N/2..N-1 and then 0..N/2-1 (DC centred); when undefined, the output runs bins 0..N-1.

Structure
REQ-026 SHALL take from shared package fft_pkg the sel encoding constants, a size-from-sel function, a log2 function and a bitrev(value, k) function.
REQ-027 SHALL instantiate one sub-module, reorder_ram: simple dual-port, one write and one read port, registered read, depth 2*MAX_N, data 2*WIDTH.

Verification
REQ-028 SHALL check: sel=11, 32 contiguous inputs di_re=p, di_im=-p -> do_re = 0,16,8,24,4,20,..., 31 and do_im its negation; first do_en 2 cycles after the last di_en.
REQ-029 SHALL check: sel=00, 16-point ramp with one idle cycle inserted after p=5 -> output 0,8,4,12,2,...,15, contiguous and 16 cycles long.
REQ-030 SHALL check: two back-to-back sel=10 frames with no gap -> 256 contiguous do_en cycles, each frame in correct order, ovf=0.
REQ-031 SHALL check: three back-to-back 128-point frames while output is stalled by design timing -> frame boundaries correct; ovf=1 if any sample was dropped, otherwise 0.
REQ-032 SHALL check: reset pulsed at input sample 10 of a 64-point frame -> no do_en; the next complete 64-point frame is output correctly.
REQ-033 SHALL check: FFT_REORDER_FFTSHIFT_EN defined, sel=11 ramp -> output bins 16..31 and then 0..15.
